// File: rtl/acc_ctrl_pkg.sv
// Shared types and helpers for the accelerator control sequencer.
// State and error encodings are visible on status_o / error_o.
package acc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WRITE       = 4'd1,
        ST_START_ACCEL = 4'd2,
        ST_WAIT        = 4'd3,
        ST_READ        = 4'd4,
        ST_DONE        = 4'd5
    } acc_state_t;

    typedef enum logic [3:0] {
        ER_OKAY        = 4'd0,
        ER_INVALID_CFG = 4'd1,
        ER_OTHERS      = 4'd2,
        ER_TIMEOUT     = 4'd3,
        ER_ABORTED     = 4'd4
    } acc_error_t;

    function automatic logic cnt_in_range(input int unsigned n, input int unsigned max_n);
        return (n != 0) && (n <= max_n);
    endfunction

    // Index width that never collapses to zero bits for single-word jobs.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/acc_ctrl_if.sv
// Data-side bundle of the sequencer: input stream, core operand/result port, output stream.
// Streams use valid/ready: a word transfers on a cycle where valid && ready; data is held while valid && !ready.
interface acc_ctrl_if #(
    parameter int DATA_W    = 32,
    parameter int IN_IDX_W  = 4,
    parameter int OUT_IDX_W = 4
);
    logic [DATA_W-1:0]    in_data_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 acc_we_o;
    logic [IN_IDX_W-1:0]  acc_waddr_o;
    logic [DATA_W-1:0]    acc_wdata_o;
    logic                 acc_start_o;
    logic                 acc_clear_o;
    logic                 acc_done_i;
    logic [OUT_IDX_W-1:0] acc_raddr_o;
    logic [DATA_W-1:0]    acc_rdata_i;
    logic [DATA_W-1:0]    out_data_o;
    logic                 out_valid_o;
    logic                 out_ready_i;

    modport master (
        output in_data_i, in_valid_i, acc_done_i, acc_rdata_i, out_ready_i,
        input  in_ready_o, acc_we_o, acc_waddr_o, acc_wdata_o, acc_start_o,
               acc_clear_o, acc_raddr_o, out_data_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_valid_i, acc_done_i, acc_rdata_i, out_ready_i,
        output in_ready_o, acc_we_o, acc_waddr_o, acc_wdata_o, acc_start_o,
               acc_clear_o, acc_raddr_o, out_data_o, out_valid_o
    );
endinterface

// File: rtl/acc_ctrl_timer.sv
// Cycle counter for the WAIT timeout. expire is high on the limit-th enabled cycle
// after clear; a limit of zero never expires.
module acc_ctrl_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire
);
    logic [W-1:0] cnt;

    assign expire = (limit != '0) && (cnt == limit - W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/acc_ctrl_fsm.sv
// Job sequencer between the register slave and an accelerator core: loads operands,
// starts the core, waits for done (with optional timeout), drains results, reports status.
module acc_ctrl_fsm
    import acc_ctrl_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int MAX_IN_WORDS  = 16,
    parameter int MAX_OUT_WORDS = 16,
    parameter int TIMEOUT_W     = 16,
    localparam int IN_CNT_W     = $clog2(MAX_IN_WORDS + 1),
    localparam int OUT_CNT_W    = $clog2(MAX_OUT_WORDS + 1),
    localparam int IN_IDX_W     = idx_width(MAX_IN_WORDS),
    localparam int OUT_IDX_W    = idx_width(MAX_OUT_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start_i,
    input  logic                 cfg_abort_i,
    input  logic [IN_CNT_W-1:0]  cfg_n_in_i,
    input  logic [OUT_CNT_W-1:0] cfg_n_out_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    input  logic                 cfg_irq_en_i,
    acc_ctrl_if.slave            bus,
    output acc_state_t           status_o,
    output acc_error_t           error_o,
    output logic                 busy_o,
    output logic                 irq_o
);
    acc_state_t           state, state_nxt;
    acc_error_t           error_q, error_nxt;
    logic [IN_CNT_W-1:0]  n_in_q, wr_cnt;
    logic [OUT_CNT_W-1:0] n_out_q, rd_cnt;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic busy, abort_busy, cfg_valid, cfg_load;
    logic in_hs, out_hs, last_in, last_out, tmo_expire;

    assign busy       = (state == ST_WRITE) || (state == ST_START_ACCEL) ||
                        (state == ST_WAIT)  || (state == ST_READ);
    assign abort_busy = cfg_abort_i && busy;
    assign cfg_valid  = cnt_in_range(32'(cfg_n_in_i), MAX_IN_WORDS) &&
                        cnt_in_range(32'(cfg_n_out_i), MAX_OUT_WORDS);
    // Abort always beats a simultaneous start, so a job only loads when abort is low.
    assign cfg_load   = cfg_start_i && !cfg_abort_i && cfg_valid &&
                        ((state == ST_IDLE) || (state == ST_DONE));
    assign in_hs      = (state == ST_WRITE) && !cfg_abort_i && bus.in_valid_i;
    assign out_hs     = (state == ST_READ)  && !cfg_abort_i && bus.out_ready_i;
    assign last_in    = (wr_cnt == n_in_q - IN_CNT_W'(1));
    assign last_out   = (rd_cnt == n_out_q - OUT_CNT_W'(1));

    acc_ctrl_timer #(.W(TIMEOUT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_START_ACCEL),
        .enable (state == ST_WAIT),
        .limit  (timeout_q),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        error_nxt = error_q;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (cfg_abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (cfg_start_i) begin
                    state_nxt = cfg_valid ? ST_WRITE : ST_DONE;
                    error_nxt = cfg_valid ? ER_OKAY : ER_INVALID_CFG;
                end
            end
            ST_WRITE:       if (in_hs && last_in) state_nxt = ST_START_ACCEL;
            ST_START_ACCEL: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.acc_done_i) begin
                    state_nxt = ST_READ;
                end else if (tmo_expire) begin
                    state_nxt = ST_DONE;
                    error_nxt = ER_TIMEOUT;
                end
            end
            ST_READ: begin
                if (out_hs && last_out) begin
                    state_nxt = ST_DONE;
                    error_nxt = ER_OKAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_busy) begin
            state_nxt = ST_DONE;
            error_nxt = ER_ABORTED;
        end
    end

    always_comb begin
        bus.in_ready_o  = (state == ST_WRITE) && !cfg_abort_i;
        bus.acc_we_o    = in_hs;
        bus.acc_waddr_o = wr_cnt[IN_IDX_W-1:0];
        bus.acc_wdata_o = bus.in_data_i;
        bus.acc_start_o = (state == ST_START_ACCEL) && !cfg_abort_i;
        bus.acc_clear_o = abort_busy ||
                          ((state == ST_WAIT) && !bus.acc_done_i && tmo_expire);
        bus.out_valid_o = (state == ST_READ) && !cfg_abort_i;
        bus.acc_raddr_o = (state == ST_READ) ? rd_cnt[OUT_IDX_W-1:0] : '0;
        bus.out_data_o  = (state == ST_READ) ? bus.acc_rdata_i : '0;
        status_o        = state;
        error_o         = error_q;
        busy_o          = busy;
        irq_o           = (state == ST_DONE) && cfg_irq_en_i;
    end

    // Job parameters are captured once at start; the register slave may change them mid-job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_in_q    <= '0;
            n_out_q   <= '0;
            timeout_q <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            error_q   <= ER_OKAY;
        end else begin
            error_q <= error_nxt;
            if (cfg_load) begin
                n_in_q    <= cfg_n_in_i;
                n_out_q   <= cfg_n_out_i;
                timeout_q <= cfg_timeout_i;
                wr_cnt    <= '0;
                rd_cnt    <= '0;
            end else begin
                if (in_hs)  wr_cnt <= wr_cnt + IN_CNT_W'(1);
                if (out_hs) rd_cnt <= rd_cnt + OUT_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm: full jobs with and without stalls, bad configs,
// timeout, aborts, ignored starts and asynchronous reset mid-job.
module tb_acc_ctrl_fsm;
    import acc_ctrl_pkg::*;

    logic        clk, rst_n;
    logic        cfg_start, cfg_abort, cfg_irq_en;
    logic [4:0]  cfg_n_in, cfg_n_out;
    logic [15:0] cfg_timeout;
    logic [3:0]  status, error;
    logic        busy, irq;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt, start_cnt, clr_cnt, out_cnt;
    logic [35:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    acc_ctrl_if #(.DATA_W(32), .IN_IDX_W(4), .OUT_IDX_W(4)) bus ();

    acc_ctrl_fsm #(
        .DATA_W(32), .MAX_IN_WORDS(16), .MAX_OUT_WORDS(16), .TIMEOUT_W(16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start_i   (cfg_start),
        .cfg_abort_i   (cfg_abort),
        .cfg_n_in_i    (cfg_n_in),
        .cfg_n_out_i   (cfg_n_out),
        .cfg_timeout_i (cfg_timeout),
        .cfg_irq_en_i  (cfg_irq_en),
        .bus           (bus),
        .status_o      (status),
        .error_o       (error),
        .busy_o        (busy),
        .irq_o         (irq)
    );

    // Core result memory model: word k reads back as D000_0000 | k.
    assign bus.acc_rdata_i = 32'hD000_0000 | 32'(bus.acc_raddr_o);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            start_cnt += int'(bus.acc_start_o);
            clr_cnt   += int'(bus.acc_clear_o);
            if (bus.acc_we_o) begin
                we_cnt++;
                if (exp_wr_q.size() == 0) check("wr_extra", 64'd1, 64'd0);
                else check("wr_word", {bus.acc_waddr_o, bus.acc_wdata_o}, exp_wr_q.pop_front());
            end
            if (bus.out_valid_o) begin
                if (exp_rd_q.size() == 0) begin
                    check("rd_extra", 64'd1, 64'd0);
                end else begin
                    check("rd_data", bus.out_data_o, exp_rd_q[0]);
                    if (bus.out_ready_i) begin
                        out_cnt++;
                        void'(exp_rd_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_wr_q.delete();
        exp_rd_q.delete();
        we_cnt = 0; start_cnt = 0; clr_cnt = 0; out_cnt = 0;
    endtask

    task automatic start_job(input int ni, input int no, input int tmo);
        cfg_n_in    = 5'(ni);
        cfg_n_out   = 5'(no);
        cfg_timeout = 16'(tmo);
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gaps);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                bus.in_valid_i = 1'b0;
                tick();
            end
            d = 32'hA000_0000 | 32'(i * 17);
            bus.in_data_i  = d;
            bus.in_valid_i = 1'b1;
            exp_wr_q.push_back({4'(i), d});
            for (int g = 0; g < 20 && !bus.in_ready_o; g++) tick();
            check("in_ready", bus.in_ready_o, 1);
            tick();
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic recv_words(input int n, input bit stall);
        for (int i = 0; i < n; i++) exp_rd_q.push_back(32'hD000_0000 | 32'(i));
        for (int i = 0; i < n; i++) begin
            if (stall && i == 1) begin
                bus.out_ready_i = 1'b0;
                repeat (4) tick();
            end
            bus.out_ready_i = 1'b1;
            for (int g = 0; g < 20 && !bus.out_valid_o; g++) tick();
            check("out_valid", bus.out_valid_o, 1);
            tick();
        end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic run_job(input int ni, input int no, input bit gaps, input bit stall, input int dly);
        clear_sb();
        start_job(ni, no, 0);
        check("lat_in_ready", bus.in_ready_o, 1);
        send_words(ni, gaps);
        check("acc_start", bus.acc_start_o, 1);
        check("st_start", status, ST_START_ACCEL);
        tick();
        check("start_1cyc", bus.acc_start_o, 0);
        repeat (dly) tick();
        bus.acc_done_i = 1'b1;
        tick();
        bus.acc_done_i = 1'b0;
        check("lat_out_valid", bus.out_valid_o, 1);
        recv_words(no, stall);
        check("job_state", status, ST_DONE);
        check("job_error", error, ER_OKAY);
        check("job_we_cnt", 64'(we_cnt), 64'(ni));
        check("job_start_cnt", 64'(start_cnt), 64'd1);
        check("job_out_cnt", 64'(out_cnt), 64'(no));
        check("job_wr_left", 64'(exp_wr_q.size()), 64'd0);
        check("job_rd_left", 64'(exp_rd_q.size()), 64'd0);
        check("job_irq", irq, cfg_irq_en);
        check("job_busy", busy, 0);
    endtask

    task automatic abort_done();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_irq_en = 1'b0;
        cfg_n_in = '0; cfg_n_out = '0; cfg_timeout = '0;
        bus.in_data_i = '0; bus.in_valid_i = 1'b0;
        bus.acc_done_i = 1'b0; bus.out_ready_i = 1'b0;
        clear_sb();
        repeat (2) tick();
        check("rst_status", status, ST_IDLE);
        check("rst_error", error, ER_OKAY);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_in_ready", bus.in_ready_o, 0);
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_clear", bus.acc_clear_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic job, irq enabled; then a stalled job straight from DONE with irq off.
        cfg_irq_en = 1'b1;
        run_job(3, 2, 1'b0, 1'b0, 4);
        cfg_irq_en = 1'b0;
        run_job(4, 3, 1'b1, 1'b1, 2);

        // Out-of-range counts, then a valid job clears the error.
        clear_sb();
        start_job(0, 2, 0);
        check("bad_nin_state", status, ST_DONE);
        check("bad_nin_error", error, ER_INVALID_CFG);
        start_job(3, 17, 0);
        tick(); tick();
        check("bad_nout_state", status, ST_DONE);
        check("bad_nout_error", error, ER_INVALID_CFG);
        check("bad_we_cnt", 64'(we_cnt), 64'd0);
        check("bad_start_cnt", 64'(start_cnt), 64'd0);
        run_job(2, 1, 1'b0, 1'b0, 1);

        // Timeout of 10 with done never arriving; config change after start must not matter.
        clear_sb();
        start_job(1, 1, 10);
        cfg_timeout = 16'd2;
        send_words(1, 1'b0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            check("tmo_wait", status, ST_WAIT);
            tick();
        end
        check("tmo_clear", bus.acc_clear_o, 1);
        tick();
        check("tmo_state", status, ST_DONE);
        check("tmo_error", error, ER_TIMEOUT);
        check("tmo_clr_cnt", 64'(clr_cnt), 64'd1);

        // Done on the 9th WAIT cycle beats the timeout.
        clear_sb();
        start_job(1, 1, 10);
        send_words(1, 1'b0);
        tick();
        repeat (8) tick();
        check("d9_wait", status, ST_WAIT);
        bus.acc_done_i = 1'b1;
        tick();
        bus.acc_done_i = 1'b0;
        check("d9_read", status, ST_READ);
        recv_words(1, 1'b0);
        check("d9_error", error, ER_OKAY);
        check("d9_clr_cnt", 64'(clr_cnt), 64'd0);

        // Abort while word 1 is offered.
        clear_sb();
        start_job(3, 2, 0);
        send_words(1, 1'b0);
        bus.in_data_i  = 32'hBAD0_0001;
        bus.in_valid_i = 1'b1;
        cfg_abort      = 1'b1;
        #1;
        check("abw_in_ready", bus.in_ready_o, 0);
        check("abw_clear", bus.acc_clear_o, 1);
        tick();
        cfg_abort = 1'b0;
        bus.in_valid_i = 1'b0;
        tick(); tick();
        check("abw_state", status, ST_DONE);
        check("abw_error", error, ER_ABORTED);
        check("abw_we_cnt", 64'(we_cnt), 64'd1);
        check("abw_start_cnt", 64'(start_cnt), 64'd0);
        check("abw_clr_cnt", 64'(clr_cnt), 64'd1);
        cfg_irq_en = 1'b1;
        #1;
        check("abw_irq", irq, 1);
        abort_done();
        check("abd_state", status, ST_IDLE);
        check("abd_irq", irq, 0);
        check("abd_error", error, ER_ABORTED);

        // Abort during READ after one result.
        clear_sb();
        start_job(1, 3, 0);
        send_words(1, 1'b0);
        tick();
        bus.acc_done_i = 1'b1;
        tick();
        bus.acc_done_i = 1'b0;
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(32'hD000_0000 | 32'(i));
        bus.out_ready_i = 1'b1;
        tick();
        cfg_abort = 1'b1;
        #1;
        check("abr_out_valid", bus.out_valid_o, 0);
        check("abr_clear", bus.acc_clear_o, 1);
        tick();
        cfg_abort = 1'b0;
        tick();
        bus.out_ready_i = 1'b0;
        check("abr_state", status, ST_DONE);
        check("abr_error", error, ER_ABORTED);
        check("abr_out_cnt", 64'(out_cnt), 64'd1);
        abort_done();

        // Start during WAIT is ignored.
        clear_sb();
        start_job(1, 1, 0);
        send_words(1, 1'b0);
        tick();
        cfg_n_in  = 5'd0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("sw_state", status, ST_WAIT);
        bus.acc_done_i = 1'b1;
        tick();
        bus.acc_done_i = 1'b0;
        recv_words(1, 1'b0);
        check("sw_done", status, ST_DONE);
        check("sw_error", error, ER_OKAY);
        check("sw_start_cnt", 64'(start_cnt), 64'd1);
        abort_done();

        // Start and abort together in IDLE.
        clear_sb();
        cfg_n_in  = 5'd2;
        cfg_n_out = 5'd2;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        tick();
        check("sa_state", status, ST_IDLE);
        check("sa_busy", busy, 0);
        check("sa_in_ready", bus.in_ready_o, 0);

        // Asynchronous reset in the middle of READ.
        clear_sb();
        start_job(2, 2, 0);
        send_words(2, 1'b0);
        tick();
        bus.acc_done_i = 1'b1;
        tick();
        bus.acc_done_i = 1'b0;
        exp_rd_q.push_back(32'hD000_0000);
        tick();
        check("rr_read", status, ST_READ);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_status", status, ST_IDLE);
        check("rr_error", error, ER_OKAY);
        check("rr_busy", busy, 0);
        check("rr_irq", irq, 0);
        check("rr_out_valid", bus.out_valid_o, 0);
        check("rr_out_data", bus.out_data_o, 0);
        check("rr_raddr", bus.acc_raddr_o, 0);
        check("rr_clear", bus.acc_clear_o, 0);
        check("rr_we", bus.acc_we_o, 0);
        check("rr_start", bus.acc_start_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_after", status, ST_IDLE);
        clear_sb();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
